// File: rtl/maze_player_ctrl.sv
// Player-token sequencer: moves one maze cell per accepted command, checks walls and grid edges, counts moves/bumps, flags the goal.
// Latency: handshake in cycle N -> updated position and moved/bumped pulse in cycle N+2, then COOLDOWN idle cycles.
// Backpressure: move_ready is high only in READY; requests during CHECK/COOL/DONE are not taken and must be held by the requester.
module maze_player_ctrl #(
   parameter int size_y   = 20,
   parameter int size_x   = 40,
   parameter int START_X  = 0,
   parameter int START_Y  = 0,
   parameter int GOAL_X   = 39,
   parameter int GOAL_Y   = 19,
   parameter int COOLDOWN = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          start,
   input  logic                          move_valid,
   input  logic [1:0]                    move_dir,
   output logic                          move_ready,
   input  logic [size_y-1:0][0:size_x-1] up_constraint,
   input  logic [size_y-1:0][0:size_x-1] down_constraint,
   input  logic [size_y-1:0][0:size_x-1] left_constraint,
   input  logic [size_y-1:0][0:size_x-1] right_constraint,
   output logic [$clog2(size_x)-1:0]     pos_x,
   output logic [$clog2(size_y)-1:0]     pos_y,
   output logic [15:0]                   move_count,
   output logic [15:0]                   bump_count,
   output logic                          moved,
   output logic                          bumped,
   output logic                          at_goal
);

   localparam int XW = $clog2(size_x);
   localparam int YW = $clog2(size_y);
   localparam int CW = (COOLDOWN > 1) ? $clog2(COOLDOWN + 1) : 1;

   localparam logic [1:0] DIR_UP    = 2'd0;
   localparam logic [1:0] DIR_DOWN  = 2'd1;
   localparam logic [1:0] DIR_LEFT  = 2'd2;
   localparam logic [1:0] DIR_RIGHT = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READY,
      ST_CHECK,
      ST_COOL,
      ST_DONE
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [1:0]      dir_q;
   logic [CW-1:0]   cool_cnt;
   logic            blocked;
   logic [XW-1:0]   nx;
   logic [YW-1:0]   ny;
   logic            do_move;
   logic            do_bump;
   logic            handshake;
   logic            pos_is_goal;
   logic            next_is_goal;

   assign move_ready   = (state == ST_READY);
   assign at_goal      = (state == ST_DONE);
   assign handshake    = move_valid && move_ready;
   assign pos_is_goal  = (pos_x == XW'(GOAL_X)) && (pos_y == YW'(GOAL_Y));
   // Where the token will sit after this CHECK: unchanged when blocked, else the target cell
   assign next_is_goal = blocked ? pos_is_goal
                                 : ((nx == XW'(GOAL_X)) && (ny == YW'(GOAL_Y)));

   // Wall/edge lookup for the latched direction plus the would-be target cell (edges never wrap)
   always_comb begin
      blocked = 1'b0;
      nx      = pos_x;
      ny      = pos_y;
      case (dir_q)
         DIR_UP: begin
            blocked = up_constraint[pos_y][pos_x] || (pos_y == '0);
            ny      = pos_y - YW'(1);
         end
         DIR_DOWN: begin
            blocked = down_constraint[pos_y][pos_x] || (pos_y == YW'(size_y - 1));
            ny      = pos_y + YW'(1);
         end
         DIR_LEFT: begin
            blocked = left_constraint[pos_y][pos_x] || (pos_x == '0);
            nx      = pos_x - XW'(1);
         end
         DIR_RIGHT: begin
            blocked = right_constraint[pos_y][pos_x] || (pos_x == XW'(size_x - 1));
            nx      = pos_x + XW'(1);
         end
         default: ;
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and move/bump decision; start overrides every other transition
   always_comb begin
      state_nxt = state;
      do_move   = 1'b0;
      do_bump   = 1'b0;
      case (state)
         ST_IDLE:  state_nxt = ST_READY;
         ST_READY: if (move_valid) state_nxt = ST_CHECK;
         ST_CHECK: begin
            do_bump = blocked;
            do_move = !blocked;
            if (COOLDOWN == 0) begin
               state_nxt = next_is_goal ? ST_DONE : ST_READY;
            end else begin
               state_nxt = ST_COOL;
            end
         end
         ST_COOL: begin
            if (cool_cnt <= CW'(1)) begin
               state_nxt = pos_is_goal ? ST_DONE : ST_READY;
            end
         end
         ST_DONE:  state_nxt = ST_DONE;
         default:  state_nxt = ST_IDLE;
      endcase
      if (start) begin
         state_nxt = ST_IDLE;
      end
   end

   // Position, saturating counters, cooldown timer and registered event pulses
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pos_x      <= XW'(START_X);
         pos_y      <= YW'(START_Y);
         dir_q      <= DIR_UP;
         cool_cnt   <= '0;
         move_count <= '0;
         bump_count <= '0;
         moved      <= 1'b0;
         bumped     <= 1'b0;
      end else if (start) begin
         pos_x      <= XW'(START_X);
         pos_y      <= YW'(START_Y);
         dir_q      <= DIR_UP;
         cool_cnt   <= '0;
         move_count <= '0;
         bump_count <= '0;
         moved      <= 1'b0;
         bumped     <= 1'b0;
      end else begin
         moved  <= do_move;
         bumped <= do_bump;
         if (handshake) begin
            dir_q <= move_dir;
         end
         if (do_move) begin
            pos_x <= nx;
            pos_y <= ny;
            if (move_count != 16'hFFFF) begin
               move_count <= move_count + 16'd1;
            end
         end
         if (do_bump && (bump_count != 16'hFFFF)) begin
            bump_count <= bump_count + 16'd1;
         end
         if (state == ST_CHECK) begin
            cool_cnt <= CW'(COOLDOWN);
         end else if ((state == ST_COOL) && (cool_cnt != '0)) begin
            cool_cnt <= cool_cnt - CW'(1);
         end
      end
   end

endmodule

// File: doc/maze_player_ctrl.md
Name: maze_player_ctrl

Overview:
- Sequences a single player token through the maze grid, one cell per accepted move command.
- Consults the four per-cell wall constraint maps produced by the maze world block.
- Applies a post-move cooldown, keeps move and bump counters, and flags arrival at the goal cell.
- Sits between the input decoder (keys/buttons) and the display/game-state logic.

Parameters:
size_y, 20, maze rows; y=0 is the top row
size_x, 40, maze columns; x=0 is the leftmost column, i.e. bit index 0 of each row vector
START_X, 0, player column after reset/start
START_Y, 0, player row after reset/start
GOAL_X, 39, goal column
GOAL_Y, 19, goal row
COOLDOWN, 4, idle cycles enforced after each accepted command (0 = none)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse: restart the game from START_X/START_Y
move_valid  input  1  move request present
move_dir  input  2  0=up, 1=down, 2=left, 3=right
move_ready  output  1  controller accepts a request this cycle
up_constraint  input  [0:size_x-1] x size_y  1 = wall blocks upward exit from cell [y][x]
down_constraint  input  [0:size_x-1] x size_y  1 = wall blocks downward exit
left_constraint  input  [0:size_x-1] x size_y  1 = wall blocks leftward exit
right_constraint  input  [0:size_x-1] x size_y  1 = wall blocks rightward exit
pos_x  output  $clog2(size_x)  current column
pos_y  output  $clog2(size_y)  current row
move_count  output  16  successful moves since start
bump_count  output  16  rejected (blocked) moves since start
moved  output  1  one-cycle pulse when the position changes
bumped  output  1  one-cycle pulse when a move is rejected
at_goal  output  1  high while in DONE

Behaviour:
- Reset (async) and start (sync) both force: state=IDLE, pos=(START_X,START_Y), move_count=0, bump_count=0, cooldown counter=0, moved=bumped=at_goal=move_ready=0.
- State IDLE: next cycle goes to READY. start in any state returns to IDLE, and start has priority over everything.
- State READY: move_ready=1 (registered from state). A handshake occurs on move_valid && move_ready. On handshake, latch move_dir and go to CHECK; otherwise stay in READY.
- State CHECK (1 cycle): index the constraint map for the latched direction at [pos_y][pos_x]. The move is blocked if either:
  - the constraint bit is 1, or
  - the target cell is off-grid: up at y=0, down at y=size_y-1, left at x=0, right at x=size_x-1. Grid edges are blocked regardless of the constraint bits; there is no wrap-around.
- On leaving CHECK:
  - Blocked: bumped pulses for 1 cycle and bump_count increments, saturating at 16'hFFFF.
  - Not blocked: pos updates, moved pulses for 1 cycle, and move_count increments (saturating).
  - Then go to COOL, loading the counter with COOLDOWN. If COOLDOWN=0, go straight to READY (or DONE).
- Latency: handshake at cycle N gives the updated pos and the moved/bumped pulse at N+2.
- State COOL: the counter decrements each cycle and move_ready=0. When the counter reaches 1, transition:
  - to DONE if pos==(GOAL_X,GOAL_Y),
  - else to READY.
  Requests presented during COOL are not accepted; they must be held by the requester.
- State DONE: at_goal=1, move_ready=0, counters frozen. Exit only via start or reset.
- The constraint inputs are sampled only in CHECK; changes to them at other times have no effect.
- move_dir is captured only at the handshake; changes to it afterwards are ignored.
- START equal to GOAL: after IDLE the controller goes to READY (the goal is tested only after a move). This is intentional.

Test Plan:
- Reset mid-COOL at (5,3) -> pos=(0,0) and move_count=0 immediately (async); move_ready=1 two cycles after reset deasserts.
- Open maze, from (0,0) issue right, right, down -> pos=(2,1), move_count=3, bump_count=0; moved pulses 2 cycles after each handshake; no accept during the 4 COOL cycles.
- At (0,0) issue up, then left -> pos unchanged, bump_count=2, two bumped pulses, moved never asserts.
- Wall test: right_constraint[0][0]=1, issue right at (0,0) -> bumped pulse, pos stays (0,0). Clear the bit, retry -> pos=(1,0).
- move_valid held high through COOL with move_dir changing -> exactly one accept per READY visit, using the dir present at the handshake.
- GOAL_X=1, GOAL_Y=0: move right from (0,0) -> at_goal=1 after cooldown and further requests ignored; a start pulse returns pos to (0,0) with counters cleared and at_goal=0.
